// File: rtl/injector_pkg.sv
// Shared types for the comparator burst injector.
// FSM state encoding and error-counter clear bit indices.
package injector_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    DELAY,
    READOUT,
    NEXT,
    REARM
  } state_e;

  localparam int ERR_THR = 0;
  localparam int ERR_OFF = 1;
  localparam int ERR_CMP = 2;

endpackage

// File: rtl/comparator_injector_burst_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/comparator_injector_burst.sv
// Burst test-pulse injector with response classification.
// Define INJECTOR_LATENCY_EN to report readout latency.
module comparator_injector_burst #(
  parameter int NSTRIPS  = 32,
  parameter int CNT_W    = 4,
  parameter int BURST_W  = 8,
  parameter int TIMEOUT  = 20,
  parameter int TMO_W    = 8,
  parameter int ERRCNT_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NSTRIPS-1:0]  halfstrips,
  input  logic [NSTRIPS-1:0]  halfstrips_expect,
  input  logic [NSTRIPS-1:0]  active_strip_mask,
  input  logic                compout,
  input  logic                compout_expect,
  input  logic                compin_inject,
  input  logic                fire_pulse,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]    pulse_width,
  input  logic [CNT_W-1:0]    bx_delay,
  input  logic [2:0]          errcnt_rst,
  output logic [NSTRIPS-1:0]  halfstrips_last,
  output logic                compout_last,
  output logic [ERRCNT_W-1:0] thresholds_errcnt,
  output logic [ERRCNT_W-1:0] offsets_errcnt,
  output logic [ERRCNT_W-1:0] compout_errcnt,
  output logic                pulse_en,
  output logic                compin,
  output logic                pulser_ready,
  output logic                burst_done,
  output logic [TMO_W-1:0]    latency
);
  import injector_pkg::*;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [TMO_W-1:0]     rd_q;
  logic [BURST_W-1:0]   issued_q, total_q;
  logic [2:0]           err_q, err_d;
  logic                 done_q;
  logic [NSTRIPS-1:0]   hs_last_q;
  logic                 co_last_q;
  logic                 trigger, timeout;

  assign trigger = |halfstrips;
  assign timeout = (rd_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire_pulse) state_d = PULSE;
      PULSE:   if (cnt_q == pulse_width) state_d = DELAY;
      DELAY:   if (cnt_q == bx_delay) state_d = READOUT;
      READOUT: if (trigger || timeout) state_d = NEXT;
      NEXT:    state_d = (issued_q < total_q) ? PULSE : REARM;
      REARM:   if (!fire_pulse) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pulse_en     = (state_q == PULSE);
    pulser_ready = (state_q == IDLE);
    compin       = pulse_en & compin_inject;
  end

  // a trigger on the last readout cycle is a response, not a timeout
  always_comb begin
    err_d = '0;
    if (state_q == READOUT) begin
      if (trigger) begin
        err_d[ERR_THR] = ~|(halfstrips & active_strip_mask);
        err_d[ERR_OFF] = (halfstrips != halfstrips_expect);
        err_d[ERR_CMP] = (compout != compout_expect);
      end else if (timeout) begin
        err_d = '1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      rd_q      <= '0;
      issued_q  <= '0;
      total_q   <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      hs_last_q <= '0;
      co_last_q <= 1'b0;
    end else begin
      cnt_q  <= (state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
      rd_q   <= (state_q == READOUT && state_d == READOUT)
                ? rd_q + TMO_W'(1) : '0;
      if (state_q == IDLE && state_d == PULSE) begin
        issued_q <= BURST_W'(1);
        total_q  <= (burst_len == '0) ? BURST_W'(1) : burst_len;
      end else if (state_q == NEXT && state_d == PULSE) begin
        issued_q <= issued_q + BURST_W'(1);
      end
      err_q  <= err_d;
      done_q <= (state_q == NEXT) && (state_d == REARM);
      if (trigger) begin
        hs_last_q <= halfstrips;
        co_last_q <= compout;
      end
    end
  end

`ifdef INJECTOR_LATENCY_EN
  logic [TMO_W-1:0] lat_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_q <= '0;
    end else if (state_q == READOUT) begin
      if (trigger)      lat_q <= rd_q;
      else if (timeout) lat_q <= '1;
    end
  end

  assign latency = lat_q;
`else
  assign latency = '0;
`endif

  sat_counter #(.W(ERRCNT_W)) u_thr (
    .clk   (clock),
    .rst_n (reset_n),
    .clr_i (errcnt_rst[ERR_THR]),
    .inc_i (err_q[ERR_THR]),
    .cnt_o (thresholds_errcnt)
  );

  sat_counter #(.W(ERRCNT_W)) u_off (
    .clk   (clock),
    .rst_n (reset_n),
    .clr_i (errcnt_rst[ERR_OFF]),
    .inc_i (err_q[ERR_OFF]),
    .cnt_o (offsets_errcnt)
  );

  sat_counter #(.W(ERRCNT_W)) u_cmp (
    .clk   (clock),
    .rst_n (reset_n),
    .clr_i (errcnt_rst[ERR_CMP]),
    .inc_i (err_q[ERR_CMP]),
    .cnt_o (compout_errcnt)
  );

  assign halfstrips_last = hs_last_q;
  assign compout_last    = co_last_q;
  assign burst_done      = done_q;

endmodule

// File: tb/tb_comparator_injector_burst.sv
// Bench for comparator_injector_burst: timeline model plus
// directed bursts with hand-computed expectations.
module tb_comparator_injector_burst;

  localparam int NS   = 32;
  localparam int CW   = 4;
  localparam int BW   = 8;
  localparam int TMO  = 20;
  localparam int TW   = 8;
  localparam int EW   = 4;
  localparam int EMAX = (1 << EW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_PULSE = 1;
  localparam int M_DELAY = 2;
  localparam int M_READ  = 3;
  localparam int M_GAP   = 4;
  localparam int M_REARM = 5;

`ifdef INJECTOR_LATENCY_EN
  localparam logic [63:0] LAT_RESP = 64'd1;
  localparam logic [63:0] LAT_TMO  = 64'hFF;
`else
  localparam logic [63:0] LAT_RESP = 64'd0;
  localparam logic [63:0] LAT_TMO  = 64'd0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NS-1:0] halfstrips = '0;
  logic [NS-1:0] halfstrips_expect = '0;
  logic [NS-1:0] active_strip_mask = '0;
  logic          compout = 1'b0;
  logic          compout_expect = 1'b0;
  logic          compin_inject = 1'b0;
  logic          fire_pulse = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic [CW-1:0] pulse_width = '0;
  logic [CW-1:0] bx_delay = '0;
  logic [2:0]    errcnt_rst = '0;

  logic [NS-1:0] halfstrips_last;
  logic          compout_last;
  logic [EW-1:0] thresholds_errcnt, offsets_errcnt, compout_errcnt;
  logic          pulse_en, compin, pulser_ready, burst_done;
  logic [TW-1:0] latency;

  comparator_injector_burst #(
    .NSTRIPS(NS), .CNT_W(CW), .BURST_W(BW),
    .TIMEOUT(TMO), .TMO_W(TW), .ERRCNT_W(EW)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .halfstrips        (halfstrips),
    .halfstrips_expect (halfstrips_expect),
    .active_strip_mask (active_strip_mask),
    .compout           (compout),
    .compout_expect    (compout_expect),
    .compin_inject     (compin_inject),
    .fire_pulse        (fire_pulse),
    .burst_len         (burst_len),
    .pulse_width       (pulse_width),
    .bx_delay          (bx_delay),
    .errcnt_rst        (errcnt_rst),
    .halfstrips_last   (halfstrips_last),
    .compout_last      (compout_last),
    .thresholds_errcnt (thresholds_errcnt),
    .offsets_errcnt    (offsets_errcnt),
    .compout_errcnt    (compout_errcnt),
    .pulse_en          (pulse_en),
    .compin            (compin),
    .pulser_ready      (pulser_ready),
    .burst_done        (burst_done),
    .latency           (latency)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Timeline model: phase + cycles-left countdown, plain integer counts.
  int            m_ph, m_left, m_issued, m_total, m_wait;
  int            m_thr, m_off, m_cmp;
  bit [2:0]      m_pend;
  bit            m_done, m_co;
  logic [NS-1:0] m_hs;
  logic [TW-1:0] m_lat;

  function automatic int bump(input int c, input bit clr, input bit inc);
    if (clr) return 0;
    if (inc && c < EMAX) return c + 1;
    return c;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = M_IDLE; m_left = 0; m_issued = 0; m_total = 0; m_wait = 0;
      m_thr = 0; m_off = 0; m_cmp = 0; m_pend = '0; m_done = 0;
      m_co = 0; m_hs = '0; m_lat = '0;
    end else begin
      if (|halfstrips) begin
        m_hs = halfstrips;
        m_co = compout;
      end
      m_thr  = bump(m_thr, errcnt_rst[0], m_pend[0]);
      m_off  = bump(m_off, errcnt_rst[1], m_pend[1]);
      m_cmp  = bump(m_cmp, errcnt_rst[2], m_pend[2]);
      m_pend = '0;
      m_done = 0;
      case (m_ph)
        M_IDLE: if (fire_pulse) begin
          m_ph = M_PULSE; m_left = int'(pulse_width) + 1;
          m_issued = 1;
          m_total = (burst_len == 0) ? 1 : int'(burst_len);
        end
        M_PULSE: begin
          m_left--;
          if (m_left == 0) begin
            m_ph = M_DELAY; m_left = int'(bx_delay) + 1;
          end
        end
        M_DELAY: begin
          m_left--;
          if (m_left == 0) begin
            m_ph = M_READ; m_wait = 0;
          end
        end
        M_READ: if (|halfstrips) begin
          m_pend[0] = ((halfstrips & active_strip_mask) == 0);
          m_pend[1] = (halfstrips != halfstrips_expect);
          m_pend[2] = (compout != compout_expect);
          m_lat = TW'(m_wait); m_ph = M_GAP;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_pend = 3'b111; m_lat = '1; m_ph = M_GAP;
          end
        end
        M_GAP: if (m_issued < m_total) begin
          m_issued++; m_ph = M_PULSE; m_left = int'(pulse_width) + 1;
        end else begin
          m_ph = M_REARM; m_done = 1;
        end
        M_REARM: if (!fire_pulse) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  int          checks = 0;
  int          fails = 0;
  int          n_pulse = 0, n_rise = 0, n_done = 0, n_cin = 0;
  int          n_mdel = 0, n_mread = 0;
  bit          prev_pe = 0;
  string       lit_nm = "";
  logic [63:0] lit_a = '0, lit_e = '0;
  bit          lit_go = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // Sole checking process: per-cycle model compare plus literal requests.
  always @(negedge clock) begin
    if (lit_go) chk(lit_nm, lit_a, lit_e);
    if (reset_n) begin
      chk("pulse_en", 64'(pulse_en), 64'(m_ph == M_PULSE));
      chk("compin", 64'(compin), 64'((m_ph == M_PULSE) && compin_inject));
      chk("pulser_ready", 64'(pulser_ready), 64'(m_ph == M_IDLE));
      chk("burst_done", 64'(burst_done), 64'(m_done));
      chk("thr_cnt", 64'(thresholds_errcnt), 64'(m_thr));
      chk("off_cnt", 64'(offsets_errcnt), 64'(m_off));
      chk("cmp_cnt", 64'(compout_errcnt), 64'(m_cmp));
      chk("hs_last", 64'(halfstrips_last), 64'(m_hs));
      chk("co_last", 64'(compout_last), 64'(m_co));
`ifdef INJECTOR_LATENCY_EN
      chk("latency", 64'(latency), 64'(m_lat));
`else
      chk("latency", 64'(latency), 64'd0);
`endif
      n_pulse += int'(pulse_en);
      n_rise  += int'(pulse_en && !prev_pe);
      n_done  += int'(burst_done);
      n_cin   += int'(compin);
      n_mdel  += int'(m_ph == M_DELAY);
      n_mread += int'(m_ph == M_READ);
      prev_pe = pulse_en;
    end else begin
      prev_pe = 0;
    end
  end

  task automatic lit(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    lit_nm = nm; lit_a = a; lit_e = e; lit_go = 1'b1;
    @(negedge clock);
    #1 lit_go = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic burst(input int bl, input int pw, input int bd,
                       input logic [NS-1:0] hs, input logic [NS-1:0] ex,
                       input logic [NS-1:0] mk, input bit co, input bit ce,
                       input bit inj, input bit resp, input int rdly,
                       input int hold);
    int g;
    burst_len = BW'(bl); pulse_width = CW'(pw); bx_delay = CW'(bd);
    halfstrips_expect = ex; active_strip_mask = mk;
    compout_expect = ce; compin_inject = inj;
    fire_pulse = 1'b1;
    tick(1);
    g = 0;
    while (m_ph != M_REARM && g < 3000) begin
      if (m_ph == M_READ && resp) begin
        tick(rdly);
        halfstrips = hs; compout = co;
        tick(1);
        halfstrips = '0; compout = 1'b0;
      end else begin
        tick(1);
      end
      g++;
    end
    lit("burst_reached_rearm", 64'(m_ph), 64'(M_REARM));
    tick(hold);
    lit("rearm_hold_not_ready", 64'(pulser_ready), 64'd0);
    fire_pulse = 1'b0;
    g = 0;
    while (m_ph != M_IDLE && g < 50) begin
      tick(1);
      g++;
    end
    tick(2);
  endtask

  int b_pulse, b_rise, b_done, b_cin, b_mdel, b_mread;

  task automatic snap();
    b_pulse = n_pulse; b_rise = n_rise; b_done = n_done;
    b_cin = n_cin; b_mdel = n_mdel; b_mread = n_mread;
  endtask

  initial begin
    int g;
    tick(2);
    lit("rst_ready", 64'(pulser_ready), 64'd1);
    lit("rst_pulse_en", 64'(pulse_en), 64'd0);
    lit("rst_off_cnt", 64'(offsets_errcnt), 64'd0);
    lit("rst_latency", 64'(latency), 64'd0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // single matching pulse, response one cycle into readout
    snap();
    burst(1, 2, 3, 32'h4, 32'h4, 32'h4, 1, 1, 1, 1, 1, 0);
    lit("t1_pulse_cycles", 64'(n_pulse - b_pulse), 64'd3);
    lit("t1_compin_cycles", 64'(n_cin - b_cin), 64'd3);
    lit("t1_delay_cycles", 64'(n_mdel - b_mdel), 64'd4);
    lit("t1_burst_done", 64'(n_done - b_done), 64'd1);
    lit("t1_thr", 64'(thresholds_errcnt), 64'd0);
    lit("t1_off", 64'(offsets_errcnt), 64'd0);
    lit("t1_cmp", 64'(compout_errcnt), 64'd0);
    lit("t1_hs_last", 64'(halfstrips_last), 64'h4);
    lit("t1_latency", 64'(latency), LAT_RESP);

    // four pulses, offset mismatch on each
    snap();
    burst(4, 1, 1, 32'h1, 32'h3, 32'h1, 0, 0, 0, 1, 0, 0);
    lit("t2_off", 64'(offsets_errcnt), 64'd4);
    lit("t2_thr", 64'(thresholds_errcnt), 64'd0);
    lit("t2_cmp", 64'(compout_errcnt), 64'd0);
    lit("t2_pulses", 64'(n_rise - b_rise), 64'd4);
    lit("t2_compin", 64'(n_cin - b_cin), 64'd0);

    // no response: full timeout
    snap();
    burst(1, 0, 0, '0, '0, '0, 0, 0, 1, 0, 0, 0);
    lit("t3_read_cycles", 64'(n_mread - b_mread), 64'd20);
    lit("t3_thr", 64'(thresholds_errcnt), 64'd1);
    lit("t3_off", 64'(offsets_errcnt), 64'd5);
    lit("t3_cmp", 64'(compout_errcnt), 64'd1);
    lit("t3_latency", 64'(latency), LAT_TMO);
    errcnt_rst = 3'b111; tick(1); errcnt_rst = 3'b000; tick(1);
    lit("t3_clr_off", 64'(offsets_errcnt), 64'd0);

    // twenty timeouts saturate all counters
    burst(20, 0, 0, '0, '0, '0, 0, 0, 1, 0, 0, 0);
    lit("t4_thr_sat", 64'(thresholds_errcnt), 64'd15);
    lit("t4_off_sat", 64'(offsets_errcnt), 64'd15);
    lit("t4_cmp_sat", 64'(compout_errcnt), 64'd15);
    errcnt_rst = 3'b111; tick(1);
    errcnt_rst = 3'b010;
    burst(1, 0, 0, 32'h1, 32'h2, 32'h1, 0, 1, 1, 1, 0, 0);
    errcnt_rst = 3'b000; tick(1);
    lit("t4_off_clr_wins", 64'(offsets_errcnt), 64'd0);
    lit("t4_thr", 64'(thresholds_errcnt), 64'd0);
    lit("t4_cmp", 64'(compout_errcnt), 64'd1);

    // reset in the middle of the delay phase
    burst_len = 8'd2; pulse_width = 4'd1; bx_delay = 4'd5;
    fire_pulse = 1'b1;
    g = 0;
    while (m_ph != M_DELAY && g < 50) begin
      tick(1);
      g++;
    end
    tick(1);
    reset_n = 1'b0;
    #1;
    lit("t5_ready", 64'(pulser_ready), 64'd1);
    lit("t5_pulse_en", 64'(pulse_en), 64'd0);
    lit("t5_compin", 64'(compin), 64'd0);
    lit("t5_done", 64'(burst_done), 64'd0);
    lit("t5_cmp", 64'(compout_errcnt), 64'd0);
    lit("t5_hs_last", 64'(halfstrips_last), 64'd0);
    lit("t5_latency", 64'(latency), 64'd0);
    fire_pulse = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    snap();
    burst(1, 1, 1, 32'h8, 32'h8, 32'h8, 1, 1, 1, 1, 0, 0);
    lit("t5_new_burst", 64'(n_rise - b_rise), 64'd1);
    lit("t5_off", 64'(offsets_errcnt), 64'd0);

    // burst_len 0 with fire held long: one pulse only
    snap();
    burst(0, 0, 0, 32'h2, 32'h2, 32'h2, 0, 0, 1, 1, 0, 100);
    lit("t6_pulses", 64'(n_rise - b_rise), 64'd1);
    lit("t6_done", 64'(n_done - b_done), 64'd1);
    lit("t6_ready", 64'(pulser_ready), 64'd1);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
